girl10_lock_param: RTL and testbench

- Parametrised successor of the small time-multiplexed-key locked controllers in the encrypted behavioural benchmark set.
- Embeds the girl10 six-state Mealy FSM. State updates happen only while the key presented on a shared key bus matches the key scheduled for the current time slot.
- Generalised: key count, key width, slot length, per-slot key values and per-slot decoy states are all parameters.
- New behaviour: an optional sticky-corruption mode.

---
 rtl/girl10_lock_param.sv | 147 ++++++++++++++
 tb/tb_girl10_lock_param.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/girl10_lock_param.sv
// girl10 six-state Mealy controller locked by a time-multiplexed key schedule.
// The state advances only while the key bus matches the key of the current slot.
module girl10_lock_param #(
  parameter int                          NUM_KEYS     = 2,
  parameter int                          KEY_WIDTH    = 6,
  parameter int                          SLOT_LEN     = 6,
  parameter logic [NUM_KEYS*KEY_WIDTH-1:0] KEY_VALUES = {6'd50, 6'd61},
  parameter logic [NUM_KEYS*3-1:0]       DECOY_STATES = {3'd3, 3'd1},
  parameter int                          STICKY       = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [KEY_WIDTH-1:0] keyinput,
  input  logic                 x1,
  input  logic                 x2,
  input  logic                 x3,
  input  logic                 x4,
  input  logic                 x5,
  input  logic                 x6,
  input  logic                 x7,
  output logic                 y1,
  output logic                 y2,
  output logic                 y3,
  output logic                 y4,
  output logic                 y6,
  output logic                 y7,
  output logic                 y8,
  output logic                 y9,
  output logic                 y10
);

  localparam int CNT_W = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
  localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

  typedef enum logic [2:0] {
    S_BAD0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3,
    S4     = 3'd4, S5 = 3'd5, S6 = 3'd6, S_BAD7 = 3'd7
  } state_t;

  typedef struct packed {
    logic y1, y2, y3, y4, y6, y7, y8, y9, y10;
  } out_t;

  if (NUM_KEYS < 1 || NUM_KEYS > 8 || KEY_WIDTH < 1 || KEY_WIDTH > 32 ||
      SLOT_LEN < 1 || SLOT_LEN > 64 || STICKY < 0 || STICKY > 1) begin : g_bad_param
    $error("girl10_lock_param: parameter out of range");
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_decoy_chk
    if (DECOY_STATES[k*3 +: 3] == 3'd0 || DECOY_STATES[k*3 +: 3] == 3'd7) begin : g_bad
      $error("girl10_lock_param: decoy state code must be 1..6");
    end
  end

  state_t             state_q, state_d, nx_state, cur_decoy;
  logic [CNT_W-1:0]   slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0]   slot_idx_q, slot_idx_d;
  logic               corrupt_q, corrupt_d;
  logic [KEY_WIDTH-1:0] cur_key;
  logic               match, slot_last, idx_last;
  out_t               out;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cur_key   = '0;
    cur_decoy = S1;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (slot_idx_q == IDX_W'(k)) begin
        cur_key   = KEY_VALUES[k*KEY_WIDTH +: KEY_WIDTH];
        cur_decoy = state_t'(DECOY_STATES[k*3 +: 3]);
      end
    end
  end

  always_comb begin
    out      = '0;
    nx_state = S1;
    unique case (state_q)
      S1: begin
        if (x6)       begin out.y8 = 1'b1; out.y9 = 1'b1; nx_state = S2; end
        else if (!x7) begin out.y3 = 1'b1; out.y6 = 1'b1; out.y10 = 1'b1; nx_state = S3; end
        else          begin out.y6 = 1'b1; nx_state = S3; end
      end
      S2: begin
        if (x4 && x1) begin out.y1 = 1'b1; out.y2 = 1'b1; nx_state = S2; end
        else if (x4)  begin out.y3 = 1'b1; out.y4 = 1'b1; nx_state = S4; end
        else          begin out.y4 = 1'b1; nx_state = S5; end
      end
      S3: begin
        if (x1 && x2 && !x3) begin out.y6 = 1'b1; out.y7 = 1'b1; nx_state = S6; end
        else if (x1)         begin out.y1 = 1'b1; out.y3 = 1'b1; nx_state = S2; end
        else                 begin out.y4 = 1'b1; nx_state = S5; end
      end
      S4: begin
        if (x6) begin out.y6 = 1'b1; out.y7 = 1'b1; nx_state = S3; end
        else    begin out.y3 = 1'b1; out.y4 = 1'b1; nx_state = S4; end
      end
      S5: begin
        if (x5)      nx_state = S1;
        else if (x1) begin out.y8 = 1'b1; out.y9 = 1'b1; nx_state = S2; end
        else         begin out.y3 = 1'b1; out.y4 = 1'b1; nx_state = S4; end
      end
      S6: begin
        out.y3 = 1'b1; out.y4 = 1'b1; nx_state = S4;
      end
      default: ;  // illegal codes: outputs stay 0, recover to s1
    endcase
  end

  // Key and decoy are taken from the slot active before this edge.
  always_comb begin
    match      = (keyinput == cur_key);
    state_d    = (match && !corrupt_q) ? nx_state : cur_decoy;
    corrupt_d  = (STICKY != 0) && (corrupt_q || !match);
    slot_last  = (slot_cnt_q == CNT_W'(SLOT_LEN - 1));
    idx_last   = (slot_idx_q == IDX_W'(NUM_KEYS - 1));
    slot_cnt_d = slot_last ? '0 : slot_cnt_q + CNT_W'(1);
    slot_idx_d = slot_idx_q;
    if (slot_last) slot_idx_d = idx_last ? '0 : slot_idx_q + IDX_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(negedge clk) begin
    if (!rst) begin
      state_q    <= S1;
      slot_cnt_q <= '0;
      slot_idx_q <= '0;
      corrupt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_cnt_q <= slot_cnt_d;
      slot_idx_q <= slot_idx_d;
      corrupt_q  <= corrupt_d;
    end
  end

  assign y1  = out.y1;
  assign y2  = out.y2;
  assign y3  = out.y3;
  assign y4  = out.y4;
  assign y6  = out.y6;
  assign y7  = out.y7;
  assign y8  = out.y8;
  assign y9  = out.y9;
  assign y10 = out.y10;

endmodule

// File: tb/tb_girl10_lock_param.sv
// Bench for girl10_lock_param: default, sticky and 3-key builds run side by side
// against a schedule-level reference model, plus directed literal expectations.
module tb_girl10_lock_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:1] x;
  logic [5:0] ka, kb;
  logic [3:0] kc;
  wire  [10:1] dy0, dy1, dy2;

  assign dy0[5] = 1'b0;
  assign dy1[5] = 1'b0;
  assign dy2[5] = 1'b0;

  girl10_lock_param u0 (
    .clk(clk), .rst(rst), .keyinput(ka),
    .x1(x[1]), .x2(x[2]), .x3(x[3]), .x4(x[4]), .x5(x[5]), .x6(x[6]), .x7(x[7]),
    .y1(dy0[1]), .y2(dy0[2]), .y3(dy0[3]), .y4(dy0[4]), .y6(dy0[6]), .y7(dy0[7]),
    .y8(dy0[8]), .y9(dy0[9]), .y10(dy0[10])
  );

  girl10_lock_param #(.STICKY(1)) u1 (
    .clk(clk), .rst(rst), .keyinput(kb),
    .x1(x[1]), .x2(x[2]), .x3(x[3]), .x4(x[4]), .x5(x[5]), .x6(x[6]), .x7(x[7]),
    .y1(dy1[1]), .y2(dy1[2]), .y3(dy1[3]), .y4(dy1[4]), .y6(dy1[6]), .y7(dy1[7]),
    .y8(dy1[8]), .y9(dy1[9]), .y10(dy1[10])
  );

  girl10_lock_param #(
    .NUM_KEYS(3), .KEY_WIDTH(4), .SLOT_LEN(2),
    .KEY_VALUES({4'd12, 4'd5, 4'd9}), .DECOY_STATES({3'd6, 3'd5, 3'd4}), .STICKY(0)
  ) u2 (
    .clk(clk), .rst(rst), .keyinput(kc),
    .x1(x[1]), .x2(x[2]), .x3(x[3]), .x4(x[4]), .x5(x[5]), .x6(x[6]), .x7(x[7]),
    .y1(dy2[1]), .y2(dy2[2]), .y3(dy2[3]), .y4(dy2[4]), .y6(dy2[6]), .y7(dy2[7]),
    .y8(dy2[8]), .y9(dy2[9]), .y10(dy2[10])
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Build configurations as seen by the model.
  int nk[3]      = '{2, 2, 3};
  int sl[3]      = '{6, 6, 2};
  int stk[3]     = '{0, 1, 0};
  int keyv[3][3] = '{'{61, 50, 0}, '{61, 50, 0}, '{9, 5, 12}};
  int dec[3][3]  = '{'{1, 3, 0}, '{1, 3, 0}, '{4, 5, 6}};

  int m_state[3];
  int m_cnt[3];
  int m_idx[3];
  bit m_corr[3];
  bit m_valid = 1'b0;

  // Transition table: outputs as a bit-per-name mask, y<n> at bit n.
  function automatic void ref_step(input int s, input logic [7:1] xi,
                                   output int nx, output logic [10:1] yv);
    yv = '0;
    nx = 1;
    case (s)
      1: if (xi[6])       begin yv[8] = 1; yv[9] = 1; nx = 2; end
         else if (!xi[7]) begin yv[3] = 1; yv[6] = 1; yv[10] = 1; nx = 3; end
         else             begin yv[6] = 1; nx = 3; end
      2: if (xi[4] && xi[1]) begin yv[1] = 1; yv[2] = 1; nx = 2; end
         else if (xi[4])     begin yv[3] = 1; yv[4] = 1; nx = 4; end
         else                begin yv[4] = 1; nx = 5; end
      3: if (xi[1] && xi[2] && !xi[3]) begin yv[6] = 1; yv[7] = 1; nx = 6; end
         else if (xi[1])               begin yv[1] = 1; yv[3] = 1; nx = 2; end
         else                          begin yv[4] = 1; nx = 5; end
      4: if (xi[6]) begin yv[6] = 1; yv[7] = 1; nx = 3; end
         else       begin yv[3] = 1; yv[4] = 1; nx = 4; end
      5: if (xi[5])      nx = 1;
         else if (xi[1]) begin yv[8] = 1; yv[9] = 1; nx = 2; end
         else            begin yv[3] = 1; yv[4] = 1; nx = 4; end
      6: begin yv[3] = 1; yv[4] = 1; nx = 4; end
      default: ;
    endcase
  endfunction

  function automatic int key_of(input int i);
    case (i)
      0:       return int'(ka);
      1:       return int'(kb);
      default: return int'(kc);
    endcase
  endfunction

  function automatic logic [10:1] dut_y(input int i);
    case (i)
      0:       return dy0;
      1:       return dy1;
      default: return dy2;
    endcase
  endfunction

  function automatic logic [31:0] dut_slot(input int i);
    case (i)
      0:       return 32'(u0.slot_idx_q);
      1:       return 32'(u1.slot_idx_q);
      default: return 32'(u2.slot_idx_q);
    endcase
  endfunction

  // Reference model: advances on every falling edge from pre-edge values.
  always @(negedge clk) begin
    int nx;
    logic [10:1] yv;
    bit match;
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        m_state[i] = 1;
        m_cnt[i]   = 0;
        m_idx[i]   = 0;
        m_corr[i]  = 1'b0;
      end else begin
        match = (key_of(i) == keyv[i][m_idx[i]]);
        ref_step(m_state[i], x, nx, yv);
        m_state[i] = (match && !m_corr[i]) ? nx : dec[i][m_idx[i]];
        if (stk[i] != 0 && !match) m_corr[i] = 1'b1;
        m_cnt[i] = (m_cnt[i] + 1) % sl[i];
        if (m_cnt[i] == 0) m_idx[i] = (m_idx[i] + 1) % nk[i];
      end
    end
    if (!rst) m_valid = 1'b1;
  end

  // Compare process: outputs and slot index on every rising edge.
  always @(posedge clk) begin
    int nx;
    logic [10:1] ey;
    if (m_valid) begin
      for (int i = 0; i < 3; i++) begin
        ref_step(m_state[i], x, nx, ey);
        check($sformatf("y_u%0d", i), 32'(dut_y(i)), 32'(ey));
        check($sformatf("slot_u%0d", i), dut_slot(i), 32'(m_idx[i]));
      end
    end
  end

  // Wait for the next falling edge, then move to just after the rising edge.
  task automatic edge_();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic good_keys();
    ka = 6'(keyv[0][m_idx[0]]);
    kb = 6'(keyv[1][m_idx[1]]);
    kc = 4'(keyv[2][m_idx[2]]);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    edge_();
    rst = 1'b1;
    good_keys();
  endtask

  int seq[7] = '{0, 0, 1, 1, 2, 2, 0};

  initial begin
    rst = 1'b0;
    x   = '0;
    ka  = '0;
    kb  = '0;
    kc  = '0;

    // Correct keys: s1 --x6--> s2, then s2 holds across the slot boundary.
    do_reset();
    x = '0; x[6] = 1'b1;
    #1 check("A_s1_x6", 32'(dy0), 32'(10'b0110000000));
    edge_();
    x = '0; x[4] = 1'b1; x[1] = 1'b1; good_keys();
    #1 check("A_s2_hold", 32'(dy0), 32'(10'b0000000011));
    repeat (7) begin edge_(); good_keys(); end
    #1 check("A_s2_after_slot", 32'(dy0), 32'(10'b0000000011));
    check("A_slot1", dut_slot(0), 32'd1);

    // Wrong key in slot 0 at edge 2, recovery at edge 3.
    do_reset();
    x = '0; x[6] = 1'b1;
    edge_();
    x = '0; x[4] = 1'b1; x[1] = 1'b1; good_keys();
    edge_();
    good_keys(); ka = '0;
    edge_();
    x = '0; good_keys();
    #1 check("B_decoy_s1", 32'(dy0), 32'(10'b1000100100));
    edge_();
    good_keys();
    #1 check("B_resume_s3", 32'(dy0), 32'(10'b0000001000));

    // Wrong key in slot 1 at edge 7.
    do_reset();
    x = '0;
    repeat (7) begin edge_(); good_keys(); end
    ka = 6'd61;
    edge_();
    x = '0; good_keys();
    #1 check("C_decoy_s3", 32'(dy0), 32'(10'b0000001000));
    edge_();
    good_keys();
    #1 check("C_s5", 32'(dy0), 32'(10'b0000001100));

    // Sticky corruption on u1 from edge 4 until reset.
    do_reset();
    x = '0;
    repeat (4) begin edge_(); good_keys(); end
    kb = '0;
    edge_();
    good_keys(); x[6] = 1'b1;
    #1 check("D_sticky_s1", 32'(dy1), 32'(10'b0110000000));
    edge_();
    good_keys();
    #1 check("D_sticky_hold", 32'(dy1), 32'(10'b0110000000));
    repeat (2) begin edge_(); good_keys(); end
    x = '0;
    #1 check("D_sticky_s3", 32'(dy1), 32'(10'b0000001000));
    do_reset();
    x = '0; x[6] = 1'b1;
    edge_();
    x = '0; x[4] = 1'b1; x[1] = 1'b1; good_keys();
    #1 check("D_restored", 32'(dy1), 32'(10'b0000000011));

    // Three-key build: slot sequence and decoy s6 in slot 2.
    do_reset();
    x = '0;
    for (int e = 0; e < 7; e++) begin
      check($sformatf("E_seq%0d", e), dut_slot(2), 32'(seq[e]));
      edge_();
      good_keys();
    end
    repeat (3) begin edge_(); good_keys(); end
    check("E_slot2", dut_slot(2), 32'd2);
    kc = 4'd5;
    edge_();
    good_keys(); x = '0;
    #1 check("E_decoy_s6", 32'(dy2), 32'(10'b0000001100));

    // Reset mid-slot at edge 8.
    do_reset();
    x = '0;
    repeat (8) begin edge_(); good_keys(); end
    rst = 1'b0; x = '0;
    edge_();
    #1 check("F_slot_idx", dut_slot(0), 32'd0);
    check("F_slot_cnt", 32'(u0.slot_cnt_q), 32'd0);
    check("F_s1_out", 32'(dy0), 32'(10'b1000100100));
    rst = 1'b1; good_keys();

    // Random traffic: mostly correct keys, occasional wrong keys and resets.
    for (int n = 0; n < 800; n++) begin
      good_keys();
      if ($urandom_range(0, 7) == 0) ka = 6'($urandom);
      if ($urandom_range(0, 15) == 0) kb = 6'($urandom);
      if ($urandom_range(0, 7) == 0) kc = 4'($urandom);
      x   = 7'($urandom);
      rst = ($urandom_range(0, 59) != 0);
      edge_();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
